// File: rtl/conv1_feed_ctrl.sv
// Feed sequencer for conv1: walks 25 steps per channel and issues BRAM reads on data steps.
// Define CONV1_FEED_STALL_EN to enable fifo_afull backpressure (STALL before low data steps).
module conv1_feed_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int ROW_WORDS  = 7,
    parameter int PAIR_WORDS = 42
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4:0]        num_ch,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        fifo_afull,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [4:0]        seq_step,
    output logic [3:0]        cnt_c,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, STALL, DONE} state_t;

    state_t            state, state_nx;
    logic [4:0]        step, step_nx, step_inc;
    logic [3:0]        c, c_nx, c_inc;
    logic [4:0]        nch, nch_nx;
    logic [ADDR_W-1:0] base, base_nx;
    logic              last, stall_req;
    logic [4:0]        dec;
    logic [31:0]       offset;
    logic              en_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [4:0]        seq_nx;
    logic [3:0]        cnt_nx;

    // Returns {data, h, r[2:0]} for a step code; data=0 marks a gap step.
    function automatic logic [4:0] decode_step(input logic [4:0] s);
        case (s)
            5'd0:    return {2'b10, 3'd0};
            5'd1:    return {2'b11, 3'd0};
            5'd2:    return {2'b10, 3'd1};
            5'd3:    return {2'b11, 3'd1};
            5'd7:    return {2'b10, 3'd2};
            5'd8:    return {2'b11, 3'd2};
            5'd12:   return {2'b10, 3'd3};
            5'd13:   return {2'b11, 3'd3};
            5'd17:   return {2'b10, 3'd4};
            5'd18:   return {2'b11, 3'd4};
            5'd22:   return {2'b10, 3'd5};
            5'd23:   return {2'b11, 3'd5};
            default: return 5'b0;
        endcase
    endfunction

    assign step_inc = (step == 5'd24) ? 5'd0 : step + 5'd1;
    assign c_inc    = (step == 5'd24) ? c + 4'd1 : c;
    assign last     = (step == 5'd24) && ({1'b0, c} == nch - 5'd1);

`ifdef CONV1_FEED_STALL_EN
    logic [4:0] dec_inc;
    assign dec_inc   = decode_step(step_inc);
    assign stall_req = dec_inc[4] && !dec_inc[3] && (fifo_afull != 4'b0);
`else
    logic unused_afull;
    assign unused_afull = ^fifo_afull;
    assign stall_req    = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        step_nx  = step;
        c_nx     = c;
        nch_nx   = nch;
        base_nx  = base;
        case (state)
            IDLE: begin
                if (start) begin
                    nch_nx   = num_ch;
                    base_nx  = base_addr;
                    step_nx  = 5'd0;
                    c_nx     = 4'd0;
                    state_nx = (num_ch == 5'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end else begin
                    step_nx  = step_inc;
                    c_nx     = c_inc;
                    state_nx = stall_req ? STALL : RUN;
                end
            end
            STALL: begin
                // step/c already hold the pending low step; resume issues it directly.
`ifdef CONV1_FEED_STALL_EN
                if (fifo_afull == 4'b0) state_nx = RUN;
`else
                state_nx = RUN;
`endif
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are computed from the next-cycle view so every registered output lines up.
    always_comb begin
        dec     = decode_step(step_nx);
        offset  = 32'(c_nx >> 1) * 32'(PAIR_WORDS) + 32'(dec[2:0]) * 32'(ROW_WORDS) + 32'(dec[3]);
        en_nx   = (state_nx == RUN) && dec[4];
        addr_nx = en_nx ? base_nx + offset[ADDR_W-1:0] : bram_addr;
        seq_nx  = (state_nx == RUN) ? step_nx : 5'd31;
        cnt_nx  = (state_nx == RUN || state_nx == STALL) ? c_nx : cnt_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= 5'd0;
            c         <= 4'd0;
            nch       <= 5'd0;
            base      <= '0;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            seq_step  <= 5'd31;
            cnt_c     <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            c         <= c_nx;
            nch       <= nch_nx;
            base      <= base_nx;
            bram_en   <= en_nx;
            bram_addr <= addr_nx;
            seq_step  <= seq_nx;
            cnt_c     <= cnt_nx;
            busy      <= (state_nx != IDLE);
            done      <= (state_nx == DONE);
        end
    end

endmodule

// File: tb/tb_conv1_feed_ctrl.sv
// Directed bench for conv1_feed_ctrl; stall scenarios adapt to CONV1_FEED_STALL_EN.
module tb_conv1_feed_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] num_ch;
    logic [9:0] base_addr;
    logic [3:0] fifo_afull;
    logic       bram_en;
    logic [9:0] bram_addr;
    logic [4:0] seq_step;
    logic [3:0] cnt_c;
    logic       busy;
    logic       done;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int en_count;
    logic [9:0] exp_addr;

    // Word offset of each step within a channel pair, -1 for gap steps.
    int step_off [0:24] = '{0, 1, 7, 8, -1, -1, -1, 14, 15, -1, -1, -1, 21, 22,
                            -1, -1, -1, 28, 29, -1, -1, -1, 35, 36, -1};

    conv1_feed_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_ch     (num_ch),
        .base_addr  (base_addr),
        .fifo_afull (fifo_afull),
        .bram_en    (bram_en),
        .bram_addr  (bram_addr),
        .seq_step   (seq_step),
        .cnt_c      (cnt_c),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_step(input int s, input int ch, input int base);
        check_output("seq_step", seq_step, s);
        check_output("cnt_c", cnt_c, ch);
        if (step_off[s] >= 0) begin
            exp_addr = 10'(base + (ch / 2) * 42 + step_off[s]);
            en_count++;
            check_output("bram_en_data", bram_en, 1);
        end else begin
            check_output("bram_en_gap", bram_en, 0);
        end
        check_output("bram_addr", bram_addr, exp_addr);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_en"}, bram_en, 0);
        check_output({tag, "_seq"}, seq_step, 31);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_done"}, done, 0);
    endtask

    task automatic check_done_cycle();
        check_output("done_pulse", done, 1);
        check_output("done_busy", busy, 1);
        check_output("done_seq", seq_step, 31);
        check_output("done_en", bram_en, 0);
        check_output("done_addr_hold", bram_addr, exp_addr);
        @(negedge clk);
        check_idle_outputs("after_done");
    endtask

    // Called at a negedge; returns at the negedge of the first RUN cycle.
    task automatic apply_stimulus(input logic [4:0] n, input logic [9:0] b);
        start     = 1'b1;
        num_ch    = n;
        base_addr = b;
        @(negedge clk);
        start     = 1'b0;
        en_count  = 0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        num_ch     = 5'd0;
        base_addr  = 10'd0;
        fifo_afull = 4'b0;
        exp_addr   = 10'd0;
        #12;
        check_idle_outputs("reset");
        check_output("reset_addr", bram_addr, 0);
        check_output("reset_cnt", cnt_c, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single channel, base 0");
        apply_stimulus(5'd1, 10'd0);
        for (int s = 0; s < 25; s++) begin
            check_step(s, 0, 0);
            @(negedge clk);
        end
        check_output("ch1_en_cycles", en_count, 12);
        check_done_cycle();

        $display("[TB] three channels, base 100, start while busy ignored");
        apply_stimulus(5'd3, 10'd100);
        for (int i = 0; i < 75; i++) begin
            check_step(i % 25, i / 25, 100);
            if (i == 50) check_output("first_ch2_addr", bram_addr, 142);
            if (i == 30) begin
                start     = 1'b1;
                num_ch    = 5'd1;
                base_addr = 10'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check_output("ch3_en_cycles", en_count, 36);
        check_done_cycle();

        $display("[TB] zero channels");
        start  = 1'b1;
        num_ch = 5'd0;
        @(negedge clk);
        start = 1'b0;
        check_output("zero_done", done, 1);
        check_output("zero_busy", busy, 1);
        check_output("zero_en", bram_en, 0);
        @(negedge clk);
        check_idle_outputs("zero_after");

        $display("[TB] backpressure held 5 cycles before step 7");
        apply_stimulus(5'd1, 10'd200);
        for (int s = 0; s < 7; s++) begin
            check_step(s, 0, 200);
            if (s == 6) fifo_afull = 4'b0100;
            @(negedge clk);
        end
`ifdef CONV1_FEED_STALL_EN
        for (int k = 0; k < 5; k++) begin
            check_output("stall_seq", seq_step, 31);
            check_output("stall_en", bram_en, 0);
            check_output("stall_busy", busy, 1);
            check_output("stall_addr_hold", bram_addr, 208);
            if (k == 4) fifo_afull = 4'b0;
            @(negedge clk);
        end
        check_output("resume_addr", bram_addr, 214);
        for (int s = 7; s < 25; s++) begin
            check_step(s, 0, 200);
            @(negedge clk);
        end
`else
        for (int s = 7; s < 25; s++) begin
            check_step(s, 0, 200);
            if (s == 10) fifo_afull = 4'b0;
            @(negedge clk);
        end
`endif
        check_done_cycle();

        $display("[TB] backpressure raised at step 2");
        apply_stimulus(5'd1, 10'd0);
        for (int s = 0; s < 7; s++) begin
            check_step(s, 0, 0);
            if (s == 2) fifo_afull = 4'b0001;
            @(negedge clk);
        end
`ifdef CONV1_FEED_STALL_EN
        check_output("late_stall_seq", seq_step, 31);
        check_output("late_stall_en", bram_en, 0);
        fifo_afull = 4'b0;
        @(negedge clk);
`else
        fifo_afull = 4'b0;
`endif
        for (int s = 7; s < 25; s++) begin
            check_step(s, 0, 0);
            @(negedge clk);
        end
        check_done_cycle();

        $display("[TB] reset at step 12 of channel 1");
        apply_stimulus(5'd2, 10'd0);
        for (int i = 0; i < 37; i++) begin
            check_step(i % 25, i / 25, 0);
            @(negedge clk);
        end
        check_step(12, 1, 0);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        check_output("midrun_reset_addr", bram_addr, 0);
        check_output("midrun_reset_cnt", cnt_c, 0);
        exp_addr = 10'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle_outputs("post_reset");
        end
        apply_stimulus(5'd1, 10'd0);
        for (int s = 0; s < 25; s++) begin
            check_step(s, 0, 0);
            @(negedge clk);
        end
        check_done_cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
